// File: rtl/pix_buf_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pix_buf_streamer : streams a window of pixel RAM as an Avalon-ST packet.
// Optional: PIX_BUF_STREAMER_CSUM_EN adds a 16-bit csum output.  Rev 1.0
// ============================================================================
module pix_buf_streamer #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop
`ifdef PIX_BUF_STREAMER_CSUM_EN
  ,
  output logic [15:0]       csum
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  len_lat;
  logic [LEN_W-1:0]  beat_cnt;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              issue;
  logic              push;
  logic              pop;
  logic              start_ok;

  // A read is only issued when a FIFO slot is guaranteed for its data.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    issue       = (state == RUN) && (credit_used < DEPTH_C);
    push        = inflight;
    src_valid   = (fifo_count != '0);
    pop         = src_valid && src_ready;
    start_ok    = (state == IDLE) && start;
  end

  assign mem_chipselect = issue;
  assign mem_address    = addr;
  assign mem_clken      = 1'b1;
  assign src_data       = fifo_mem[rd_ptr];
  assign src_sop        = src_valid && (beat_cnt == '0);
  assign src_eop        = src_valid && (beat_cnt == (len_lat - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (issue && (rem == LEN_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave as the final beat is accepted so done follows it directly.
        if (!inflight && ((fifo_count == '0) ||
                          ((fifo_count == CNT_W'(1)) && pop))) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      rem        <= '0;
      len_lat    <= '0;
      beat_cnt   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      inflight <= issue;

      if (start_ok) begin
        addr    <= base_addr;
        rem     <= length;
        len_lat <= length;
      end else if (issue) begin
        addr <= addr + ADDR_W'(1);
        rem  <= rem - LEN_W'(1);
      end

      if (start_ok) begin
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end

      if (push) begin
        fifo_mem[wr_ptr] <= mem_readdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef PIX_BUF_STREAMER_CSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum + 16'(src_data);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pix_buf_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// Directed scoreboard bench for pix_buf_streamer with a behavioural RAM model.
module tb_pix_buf_streamer;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;
  localparam int LEN_W      = 16;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;
`ifdef PIX_BUF_STREAMER_CSUM_EN
  logic [15:0]       csum;
`endif

  pix_buf_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop)
`ifdef PIX_BUF_STREAMER_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [9:0]  sb[$];
  logic [14:0] addr_log[$];
  int          cs_cnt = 0, valid_cnt = 0, acc_cnt = 0, extra_beats = 0;
  int          overflow_cnt = 0, max_fill = 0, sop_cyc = 0, eop_cyc = 0;
  bit          throttle = 0;
  bit          stall_prev = 0;
  logic [7:0]  stall_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic monitor();
    logic [9:0] e;
    if (reset) begin
      stall_prev = 0;
      return;
    end
    if (mem_chipselect) begin
      cs_cnt++;
      addr_log.push_back(mem_address);
    end
    if (src_valid) valid_cnt++;
    if (32'(dut.fifo_count) > max_fill) max_fill = 32'(dut.fifo_count);
    if (dut.inflight && (32'(dut.fifo_count) == FIFO_DEPTH) && !(src_valid && src_ready))
      overflow_cnt++;
    if (stall_prev) begin
      check("hold_valid", src_valid, 1);
      check("hold_data", src_data, stall_data);
    end
    if (src_valid && src_ready) begin
      acc_cnt++;
      if (src_sop) sop_cyc = cyc;
      if (src_eop) eop_cyc = cyc;
      if (sb.size() == 0) begin
        extra_beats++;
      end else begin
        e = sb.pop_front();
        check("beat_data", src_data, e[9:2]);
        check("beat_sop", src_sop, e[1]);
        check("beat_eop", src_eop, e[0]);
      end
    end
    stall_prev = src_valid && !src_ready;
    stall_data = src_data;
  endtask

  // One clock: observe at the falling edge, then update inputs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    src_ready = throttle ? ((cyc % 4) == 0) : 1'b1;
  endtask

  task automatic do_start(input logic [14:0] base, input logic [15:0] len);
    for (int i = 0; i < int'(len); i++) begin
      logic [14:0] a;
      a = base + 15'(i);
      sb.push_back({ram[a], (i == 0), (i == int'(len) - 1)});
    end
    base_addr = base;
    length    = len;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int waited);
    waited = 0;
    while (!done && waited < bound) begin
      tick();
      waited++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, done, mem_chipselect, mem_clken, src_valid, src_sop, src_eop},
          7'b0001000);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_data"}, src_data, 0);
`ifdef PIX_BUF_STREAMER_CSUM_EN
    check({tag, "_csum"}, csum, 0);
`endif
  endtask

  initial begin
    int w, s, c0, v0, x0, dcount, n;
    logic [14:0] ea [4];

    for (int i = 0; i < 32768; i++) ram[i] = 8'(i * 7 + 3);
    ram[15'h0100] = 8'h11; ram[15'h0101] = 8'h22;
    ram[15'h0102] = 8'h33; ram[15'h0103] = 8'h44;
    ram[15'h7FFE] = 8'hA0; ram[15'h7FFF] = 8'hA1;
    ram[15'h0000] = 8'hA2; ram[15'h0001] = 8'hA3;
    ram[15'h0005] = 8'h5A;

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; src_ready = 1'b1;
    tick(); tick();
    check_reset_outputs("por");
    reset = 1'b0;
    tick();

    // Basic packet with sop/eop and back-to-back beats.
    s = acc_cnt;
    do_start(15'h0100, 16'd4);
    wait_done(100, w);
    check("t1_done_after_eop", cyc, eop_cyc + 1);
    check("t1_back_to_back", eop_cyc - sop_cyc, 3);
    check("t1_beats", acc_cnt - s, 4);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_busy_in_fin", busy, 0);
`ifdef PIX_BUF_STREAMER_CSUM_EN
    check("t1_csum", csum, 16'h00AA);
`endif
    tick();
    check("t1_done_one_cycle", done, 0);

    // Address wrap past the top of the RAM.
    addr_log.delete();
    do_start(15'h7FFE, 16'd4);
    wait_done(100, w);
    ea[0] = 15'h7FFE; ea[1] = 15'h7FFF; ea[2] = 15'h0000; ea[3] = 15'h0001;
    check("t2_addr_count", addr_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (addr_log.size() > 0) check("t2_addr", addr_log.pop_front(), ea[k]);
    end
    check("t2_sb_empty", sb.size(), 0);
    tick();

    // Heavy backpressure: ready one cycle in four.
    throttle = 1'b1;
    s = acc_cnt;
    do_start(15'h0300, 16'd16);
    wait_done(1000, w);
    throttle = 1'b0;
    check("t3_done_after_eop", cyc, eop_cyc + 1);
    check("t3_beats", acc_cnt - s, 16);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_fill_le_depth", (max_fill <= FIFO_DEPTH), 1);
    check("t3_no_overflow", overflow_cnt, 0);
    tick();

    // Zero-length start.
    c0 = cs_cnt; v0 = valid_cnt;
    do_start(15'h0100, 16'd0);
    wait_done(10, w);
    check("t4_done_next_cycle", w, 0);
    check("t4_no_reads", cs_cnt - c0, 0);
    check("t4_no_valid", valid_cnt - v0, 0);
    check("t4_busy", busy, 0);
    tick();
    check("t4_done_one_cycle", done, 0);

    // Single beat, plus a start while busy that must be ignored.
    c0 = cs_cnt; x0 = extra_beats; s = acc_cnt;
    do_start(15'h0005, 16'd1);
    check("t5_busy", busy, 1);
    base_addr = 15'h0100; length = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, w);
    for (int k = 0; k < 10; k++) tick();
    check("t5_beats", acc_cnt - s, 1);
    check("t5_reads", cs_cnt - c0, 1);
    check("t5_no_extra", extra_beats - x0, 0);
    check("t5_idle", busy, 0);

    // Reset in the middle of a transfer.
    s = acc_cnt; n = 0;
    do_start(15'h0200, 16'd8);
    while ((acc_cnt - s) < 3 && n < 50) begin
      tick();
      n++;
    end
    check("t6_three_beats", acc_cnt - s, 3);
    reset = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    reset = 1'b0;
    sb.delete();
    dcount = 0; v0 = valid_cnt;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) dcount++;
    end
    check("t6_no_done", dcount, 0);
    check("t6_no_valid", valid_cnt - v0, 0);
    s = acc_cnt;
    do_start(15'h0100, 16'd4);
    wait_done(100, w);
    check("t6_fresh_beats", acc_cnt - s, 4);
    check("t6_fresh_sb_empty", sb.size(), 0);
`ifdef PIX_BUF_STREAMER_CSUM_EN
    check("t6_csum", csum, 16'h00AA);
`endif
    tick();

    check("no_extra_beats", extra_beats, 0);
    check("no_overflow", overflow_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
